// File: rtl/ps_window_sum_pkg.sv
// ps_pkg: shared constants, types and helpers for the windowed power path.
//   PS_DATA_W      default width of a squared sample
//   PS_WINDOW_LEN  default window length (power of two, >= 2)
//   ps_sum_width() accumulator width that cannot overflow for a full window
//   ps_sample_t    squared-sample word at the default width
package ps_pkg;

    localparam int PS_DATA_W     = 64;
    localparam int PS_WINDOW_LEN = 16;

    typedef logic [PS_DATA_W-1:0] ps_sample_t;

    // A window of N samples needs log2(N) extra bits above the sample width.
    function automatic int ps_sum_width(input int data_w, input int window_len);
        return data_w + $clog2(window_len);
    endfunction

endpackage

// File: rtl/ps_window_sum_delay_ram.sv
// ps_delay_ram: WINDOW_LEN x DATA_W circular delay buffer.
//   clk      clock
//   i_we     write enable (synchronous write)
//   i_addr   shared read/write address
//   i_wdata  write data
//   o_rdata  asynchronous read of the entry at i_addr (value before the write)
// No reset: the consumer never uses an entry before it has been written.
module ps_delay_ram #(
    parameter int DATA_W     = 64,
    parameter int WINDOW_LEN = 16,
    localparam int ADDR_W    = $clog2(WINDOW_LEN)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [WINDOW_LEN];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ps_window_sum.sv
// ps_window_sum: running sum of the last WINDOW_LEN squared samples.
//   clk, rst     clock, synchronous active-high reset
//   clr          synchronous window flush (drops a coincident sample)
//   din          squared sample (nonnegative, treated as unsigned)
//   din_valid    sample strobe, one sample per cycle, no backpressure
//   sum          registered window sum, updated one cycle after din_valid
//   sum_valid    one-cycle pulse per update while the window is full
//   window_full  level, high once WINDOW_LEN samples accepted since rst/clr
// Optional (macro PS_SUM_THRESH_EN):
//   thresh       comparison threshold
//   alarm        registered (sum > thresh), refreshed only with sum_valid
module ps_window_sum
    import ps_pkg::*;
#(
    parameter int DATA_W     = PS_DATA_W,
    parameter int WINDOW_LEN = PS_WINDOW_LEN,
    localparam int ADDR_W    = $clog2(WINDOW_LEN),
    localparam int SUM_W     = ps_sum_width(DATA_W, WINDOW_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    output logic        [SUM_W-1:0]  sum,
    output logic                     sum_valid,
    output logic                     window_full
`ifdef PS_SUM_THRESH_EN
    ,
    input  logic        [SUM_W-1:0]  thresh,
    output logic                     alarm
`endif
);

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(WINDOW_LEN);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(WINDOW_LEN - 1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic [SUM_W-1:0]  r_sum;
    logic              r_sum_valid;
    logic              r_full;

    logic              w_accept;
    logic [DATA_W-1:0] w_oldest;
    logic [SUM_W-1:0]  w_din_ext;
    logic [SUM_W-1:0]  w_sub;
    logic [SUM_W-1:0]  w_sum_next;
    logic              w_post_full;

    // clr drops the coincident sample, so it must also block the buffer write.
    assign w_accept = din_valid && !rst && !clr;

    ps_delay_ram #(
        .DATA_W     (DATA_W),
        .WINDOW_LEN (WINDOW_LEN)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_wr_ptr),
        .i_wdata ($unsigned(din)),
        .o_rdata (w_oldest)
    );

    assign w_din_ext   = {{ADDR_W{1'b0}}, $unsigned(din)};
    // Buffer is never cleared; until full the entry under wr_ptr is stale.
    assign w_sub       = r_full ? {{ADDR_W{1'b0}}, w_oldest} : '0;
    assign w_sum_next  = r_sum + w_din_ext - w_sub;
    // Post-update count reaches WINDOW_LEN on the filling sample and stays there.
    assign w_post_full = (r_count >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (din_valid) begin
                r_sum       <= w_sum_next;
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_count     <= (r_count == CNT_FULL) ? CNT_FULL : r_count + 1'b1;
                r_sum_valid <= w_post_full;
                if (w_post_full) r_full <= 1'b1;
            end
        end
    end

    assign sum         = r_sum;
    assign sum_valid   = r_sum_valid;
    assign window_full = r_full;

`ifdef PS_SUM_THRESH_EN
    logic r_alarm;

    always_ff @(posedge clk) begin
        if (rst || clr)                   r_alarm <= 1'b0;
        else if (din_valid && w_post_full) r_alarm <= (w_sum_next > thresh);
    end

    assign alarm = r_alarm;
`endif

endmodule

// File: tb/tb_ps_window_sum.sv
module tb_ps_window_sum;

    localparam int DW = 64;
    localparam int WL = 4;
    localparam int SW = DW + $clog2(WL);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clr = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic                 din_valid = 1'b0;
    logic        [SW-1:0] sum;
    logic                 sum_valid;
    logic                 window_full;
`ifdef PS_SUM_THRESH_EN
    logic        [SW-1:0] thresh = '0;
    logic                 alarm;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    // reference model: the window as a list of the most recent samples
    logic [DW-1:0] win[$];
    logic [SW-1:0] m_sum   = '0;
    logic          m_sv    = 1'b0;
    logic          m_alarm = 1'b0;

    ps_window_sum #(.DATA_W(DW), .WINDOW_LEN(WL)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .din         (din),
        .din_valid   (din_valid),
        .sum         (sum),
        .sum_valid   (sum_valid),
        .window_full (window_full)
`ifdef PS_SUM_THRESH_EN
        ,
        .thresh      (thresh),
        .alarm       (alarm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit v, input logic [DW-1:0] d,
                              input logic [SW-1:0] th);
        if (r || c) begin
            win.delete();
            m_sum   = '0;
            m_sv    = 1'b0;
            m_alarm = 1'b0;
        end else if (v) begin
            win.push_back(d);
            if (win.size() > WL) void'(win.pop_front());
            m_sum = '0;
            foreach (win[i]) m_sum += SW'(win[i]);
            m_sv = (win.size() == WL);
            if (m_sv) m_alarm = (m_sum > th);
        end else begin
            m_sv = 1'b0;
        end
    endtask

    // drive one cycle, advance the model, check #1 after the edge
    task automatic cyc(input bit r, input bit c, input bit v, input logic [DW-1:0] d);
        logic [SW-1:0] th;
        th = '0;
`ifdef PS_SUM_THRESH_EN
        th = thresh;
`endif
        rst = r; clr = c; din_valid = v; din = d;
        @(posedge clk);
        model_step(r, c, v, d, th);
        #1;
        chk("sum", sum, m_sum);
        chk("sum_valid", SW'(sum_valid), SW'(m_sv));
        chk("window_full", SW'(window_full), SW'(win.size() == WL));
`ifdef PS_SUM_THRESH_EN
        chk("alarm", SW'(alarm), SW'(m_alarm));
`endif
    endtask

    initial begin
        logic [DW-1:0] big;
        big = 64'h4000_0000_0000_0000;
`ifdef PS_SUM_THRESH_EN
        thresh = 66'd9;
`endif
        // reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 64'd77);
        chk("reset_sum", sum, '0);

        // fill then steady with pointer wrap
        cyc(0, 0, 1, 1); cyc(0, 0, 1, 2); cyc(0, 0, 1, 3);
        chk("fill_no_valid", SW'(sum_valid), '0);
        cyc(0, 0, 1, 4);
        chk("first_full_sum", sum, 66'd10);
        cyc(0, 0, 1, 5);
        chk("wrap_sum1", sum, 66'd14);
        cyc(0, 0, 1, 6);
        chk("wrap_sum2", sum, 66'd18);

        // valid gaps
        cyc(0, 0, 1, 7); cyc(0, 0, 0, 99); cyc(0, 0, 1, 8); cyc(0, 0, 0, 99);
        chk("gap_sum", sum, 66'd26);

`ifdef PS_SUM_THRESH_EN
        // alarm falls as the window drains to zero
        cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
        chk("alarm_drained", SW'(alarm), '0);
`endif

        // clr with coincident sample drops it
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 1); cyc(0, 0, 1, 2); cyc(0, 0, 1, 3); cyc(0, 0, 1, 4);
        cyc(0, 1, 1, 9);
        chk("clr_sum", sum, '0);
        chk("clr_full", SW'(window_full), '0);
        cyc(0, 0, 1, 1); cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
        chk("clr_refill_no_valid", SW'(sum_valid), '0);
        cyc(0, 0, 1, 1);
        chk("clr_refill_sum", sum, 66'd4);

        // wide samples, no overflow
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, big);
        chk("big_sum", sum, 66'h1_0000_0000_0000_0000);

        // reset mid-window then randomized traffic
        cyc(0, 0, 1, 3); cyc(1, 0, 1, 5);
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] d;
            bit r, c, v;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 4);
            v = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 1) == 1) d = DW'($urandom_range(0, 20));
            else                           d = {1'b0, 31'($urandom), 32'($urandom)};
`ifdef PS_SUM_THRESH_EN
            if ($urandom_range(0, 19) == 0) thresh = SW'($urandom_range(0, 60));
`endif
            cyc(r, c, v, d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/ps_window_sum.md
Name: ps_window_sum

Overview:
- Sliding-window power accumulator, directly downstream of the per-sample squaring stage.
- Consumes squared samples (din^2) and their valid strobe.
- Maintains a running sum of the most recent WINDOW_LEN squared samples, using a circular delay buffer.
- Emits the windowed signal power once per accepted sample after the window has filled.

Parameters:
- DATA_W, 64, width of incoming squared sample; nonnegative by construction.
- WINDOW_LEN, 16, number of samples in the window; power of two, at least 2.
- ADDR_W, $clog2(WINDOW_LEN), buffer pointer width; derived, do not override.
- SUM_W, DATA_W+ADDR_W, accumulator width; guarantees no overflow.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- clr, input, 1, synchronous window flush, active high.
- din, input, DATA_W, squared sample from the upstream stage. The port is signed, but values are always at least 0; arithmetic treats it as unsigned.
- din_valid, input, 1, active high; driven by the upstream data_valid.
- sum, output, SUM_W, registered windowed power sum.
- sum_valid, output, 1, one-cycle pulse per updated sum while the window is full.
- window_full, output, 1, level; high once WINDOW_LEN samples have been accepted since rst/clr.

Behaviour:
- Reset (rst=1, sync) clears:
  - sum, sum_valid, window_full to 0;
  - wr_ptr to 0;
  - fill count to 0.
- Buffer contents are not cleared. The subtract path is gated by window_full, so stale data is never used.
- Accepting a sample (din_valid=1, rst=0, clr=0):
  - oldest = buf[wr_ptr], read combinationally.
  - sum <= sum + din - (window_full ? oldest : 0).
  - buf[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1; wraps from WINDOW_LEN-1 to 0 naturally.
  - count <= min(count+1, WINDOW_LEN).
- Latency: sum updates on the clk edge that accepts the sample, i.e. visible 1 cycle after din_valid.
- window_full is set on the edge that accepts the WINDOW_LEN-th sample. It stays high until rst or clr.
- sum_valid: registered. It is high for exactly one cycle after each accepted sample whose post-update count equals WINDOW_LEN. The first pulse coincides with window_full rising.
- din_valid=0: sum, wr_ptr, count and buffer hold; sum_valid=0.
- clr=1 behaves as a reset of sum, sum_valid, window_full, wr_ptr and count. It has priority over a simultaneous din_valid; that sample is dropped.
- rst has priority over clr.
- Reset mid-window: all state is discarded and the next sample starts a new window.
- No backpressure: one sample per cycle is always accepted.
- States (implicit in count/window_full):
  - FILLING: count < WINDOW_LEN, no subtract, sum_valid=0.
  - STEADY: subtract oldest, sum_valid pulses.
  - FILLING -> STEADY on the WINDOW_LEN-th sample.
  - Any state -> FILLING on rst or clr.

Optional Feature:
- Macro PS_SUM_THRESH_EN.
- Defined:
  - Adds input thresh [SUM_W-1:0] and output alarm [1].
  - alarm is registered. It is updated only together with sum_valid: alarm <= (new sum > thresh) on each sum_valid cycle, and holds otherwise.
  - alarm is cleared by rst and by clr.
- Undefined: thresh and alarm ports and their logic are absent.

Decomposition:
- Shared package ps_pkg holds:
  - default DATA_W (64) and WINDOW_LEN (16) constants;
  - function ps_sum_width(data_w, window_len) returning data_w + $clog2(window_len);
  - typedef ps_sample_t for the squared-sample word.
- One natural sub-module: ps_delay_ram.
  - WINDOW_LEN x DATA_W register array.
  - Synchronous write, asynchronous read at the same address.
  - No reset.

Test Plan:
- WINDOW_LEN=4, rst, then din=1,2,3,4 back-to-back:
  - sum = 1,3,6,10 on successive cycles;
  - sum_valid and window_full first high with sum=10.
- Continue with din=5,6:
  - sum = 14 (10+5-1), then 18 (14+6-2);
  - sum_valid pulses on each;
  - confirms pointer wrap.
- Fill window, then din_valid gaps (valid 1010 pattern, values 7,8):
  - sum changes only on valid cycles;
  - sum_valid=0 on idle cycles.
- Window full at sum=10, assert clr together with din_valid, din=9:
  - next cycle sum=0, window_full=0, sample dropped;
  - next 4 samples 1,1,1,1 produce sum_valid only at sum=4.
- din = 2^62 for 5 samples:
  - sum = 2^64 (no overflow, SUM_W=66) and stays 2^64 on sample 5.
- With PS_SUM_THRESH_EN, thresh=9, din=1,2,3,4:
  - alarm=0 until the sum=10 sum_valid cycle, then alarm=1;
  - din=0 x4 drops sum to 0 and alarm returns to 0 on that update.
